// File: rtl/fetch_unit.sv
// Fetch stage: walks the PC, issues one 64-bit I-cache read at a time, packs an instruction pair per push.
// Latency: REQ -> WAIT -> HOLD, so one group every 3 cycles when the cache answers in one cycle each way.
// Backpressure: buffer_full holds the group stable in HOLD with no new request; flush overrides everything.
module fetch_unit #(
    parameter logic [31:0]      RESET_PC = 32'hBFC00000,
    parameter int               EXC_W    = 4,
    parameter logic [EXC_W-1:0] EXC_NONE = '0,
    parameter logic [EXC_W-1:0] EXC_ADEL = EXC_W'(4)
) (
    input  logic              clk,
    input  logic              reset,
    // instruction cache
    output logic              inst_req,
    output logic [31:0]       inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [63:0]       inst_rdata,
    // branch predictor / RAS
    output logic [31:0]       bp_pc,
    input  logic              bp_taken0,
    input  logic              bp_taken1,
    input  logic [31:0]       bp_target0,
    input  logic [31:0]       bp_target1,
    input  logic [63:0]       ras_in,
    // redirect from commit
    input  logic              flush,
    input  logic [31:0]       flush_target,
    // instruction buffer push
    input  logic              buffer_full,
    output logic              fetch_output_en,
    output logic              fetch_valid0,
    output logic              fetch_valid1,
    output logic [31:0]       fetch_PC0,
    output logic [31:0]       fetch_PC1,
    output logic [31:0]       fetch_inst0,
    output logic [31:0]       fetch_inst1,
    output logic              fetch_predict0,
    output logic              fetch_predict1,
    output logic [31:0]       fetch_predict_target0,
    output logic [31:0]       fetch_predict_target1,
    output logic [EXC_W-1:0]  fetch_excode0,
    output logic [EXC_W-1:0]  fetch_excode1,
    output logic [63:0]       fetch_RAS
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_CANCEL = 3'd4,
        S_STALL  = 3'd5
    } state_t;

    state_t            r_state;
    logic [31:0]       r_pc;
    logic              r_pend;       // next group's first slot is a delay slot
    logic [31:0]       r_pend_tgt;   // where to go after that delay slot
    logic              r_adel;       // group in HOLD is a misaligned-fetch report

    logic              r_valid0, r_valid1;
    logic [31:0]       r_pc0, r_pc1, r_inst0, r_inst1;
    logic              r_pred0, r_pred1;
    logic [31:0]       r_tgt0, r_tgt1;
    logic [EXC_W-1:0]  r_exc0, r_exc1;
    logic [63:0]       r_ras;

    logic              w_aligned;
    logic              w_req;
    logic              w_accept;
    logic              w_cancel_on_flush;
    logic              w_v1;
    logic              w_p0;
    logic              w_p1;
    logic [31:0]       w_next_pc;
    logic              w_pend_nxt;
    logic [31:0]       w_pend_tgt_nxt;

    assign w_aligned = (r_pc[1:0] == 2'b00);
    assign w_req     = (r_state == S_REQ) && w_aligned;
    assign w_accept  = w_req && inst_addr_ok;

    // A request is still in flight after this edge if the cache owes us data.
    assign w_cancel_on_flush = ((r_state == S_WAIT)   && !inst_data_ok) ||
                               w_accept ||
                               ((r_state == S_CANCEL) && !inst_data_ok);

    assign inst_req        = w_req;
    assign inst_addr       = w_req ? {r_pc[31:3], 3'b000} : 32'h0;
    assign bp_pc           = (r_state == S_IDLE) ? 32'h0 : r_pc;
    assign fetch_output_en = (r_state == S_HOLD);

    assign fetch_valid0          = r_valid0;
    assign fetch_valid1          = r_valid1;
    assign fetch_PC0             = r_pc0;
    assign fetch_PC1             = r_pc1;
    assign fetch_inst0           = r_inst0;
    assign fetch_inst1           = r_inst1;
    assign fetch_predict0        = r_pred0;
    assign fetch_predict1        = r_pred1;
    assign fetch_predict_target0 = r_tgt0;
    assign fetch_predict_target1 = r_tgt1;
    assign fetch_excode0         = r_exc0;
    assign fetch_excode1         = r_exc1;
    assign fetch_RAS             = r_ras;

    // Next-PC and slot-validity decode for the request being accepted (first match wins).
    always_comb begin
        w_v1           = 1'b1;
        w_p0           = 1'b0;
        w_p1           = 1'b0;
        w_next_pc      = r_pc + 32'd8;
        w_pend_nxt     = 1'b0;
        w_pend_tgt_nxt = r_pend_tgt;
        if (r_pend) begin
            // delay slot only, then jump to the remembered target
            w_v1      = 1'b0;
            w_next_pc = r_pend_tgt;
        end else if (r_pc[2]) begin
            // odd-word entry: only one instruction left in this doubleword
            w_v1      = 1'b0;
            w_next_pc = r_pc + 32'd4;
            if (bp_taken0) begin
                w_p0           = 1'b1;
                w_pend_nxt     = 1'b1;
                w_pend_tgt_nxt = bp_target0;
            end
        end else if (bp_taken0) begin
            // slot1 is the delay slot of slot0, so the whole pair is used
            w_p0      = 1'b1;
            w_next_pc = bp_target0;
        end else if (bp_taken1) begin
            // delay slot of slot1 lives in the next doubleword
            w_p1           = 1'b1;
            w_pend_nxt     = 1'b1;
            w_pend_tgt_nxt = bp_target1;
        end
    end

    // Fetch FSM, PC walk and group register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_tgt <= 32'h0;
            r_adel     <= 1'b0;
            r_valid0   <= 1'b0;
            r_valid1   <= 1'b0;
            r_pc0      <= 32'h0;
            r_pc1      <= 32'h0;
            r_inst0    <= 32'h0;
            r_inst1    <= 32'h0;
            r_pred0    <= 1'b0;
            r_pred1    <= 1'b0;
            r_tgt0     <= 32'h0;
            r_tgt1     <= 32'h0;
            r_exc0     <= EXC_NONE;
            r_exc1     <= EXC_NONE;
            r_ras      <= 64'h0;
        end else if (flush) begin
            r_pc    <= flush_target;
            r_pend  <= 1'b0;
            r_adel  <= 1'b0;
            r_state <= w_cancel_on_flush ? S_CANCEL : S_REQ;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (!w_aligned) begin
                        // report the bad address as a single-slot exception group
                        r_valid0 <= 1'b1;
                        r_valid1 <= 1'b0;
                        r_pc0    <= r_pc;
                        r_pc1    <= r_pc + 32'd4;
                        r_inst0  <= 32'h0;
                        r_inst1  <= 32'h0;
                        r_pred0  <= 1'b0;
                        r_pred1  <= 1'b0;
                        r_tgt0   <= 32'h0;
                        r_tgt1   <= 32'h0;
                        r_exc0   <= EXC_ADEL;
                        r_exc1   <= EXC_NONE;
                        r_ras    <= ras_in;
                        r_adel   <= 1'b1;
                        r_state  <= S_HOLD;
                    end else if (inst_addr_ok) begin
                        r_valid0   <= 1'b1;
                        r_valid1   <= w_v1;
                        r_pc0      <= r_pc;
                        r_pc1      <= r_pc + 32'd4;
                        r_pred0    <= w_p0;
                        r_pred1    <= w_p1;
                        r_tgt0     <= bp_target0;
                        r_tgt1     <= bp_target1;
                        r_exc0     <= EXC_NONE;
                        r_exc1     <= EXC_NONE;
                        r_ras      <= ras_in;
                        r_pc       <= w_next_pc;
                        r_pend     <= w_pend_nxt;
                        r_pend_tgt <= w_pend_tgt_nxt;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        r_inst0 <= r_pc0[2] ? inst_rdata[63:32] : inst_rdata[31:0];
                        r_inst1 <= inst_rdata[63:32];
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!buffer_full) begin
                        r_state <= r_adel ? S_STALL : S_REQ;
                        r_adel  <= 1'b0;
                    end
                end
                S_CANCEL: begin
                    if (inst_data_ok) begin
                        r_state <= S_REQ;
                    end
                end
                S_STALL: r_state <= S_STALL;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases push expected groups/requests into queues.
// Latency: a negedge monitor pops and compares every push and every accepted cache request.
// Backpressure: buffer_full and cache handshakes are driven by the stimulus process.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic [31:0] bp_pc;
    logic        bp_taken0, bp_taken1;
    logic [31:0] bp_target0, bp_target1;
    logic [63:0] ras_in;
    logic        flush;
    logic [31:0] flush_target;
    logic        buffer_full;
    logic        fetch_output_en;
    logic        fetch_valid0, fetch_valid1;
    logic [31:0] fetch_PC0, fetch_PC1, fetch_inst0, fetch_inst1;
    logic        fetch_predict0, fetch_predict1;
    logic [31:0] fetch_predict_target0, fetch_predict_target1;
    logic [3:0]  fetch_excode0, fetch_excode1;
    logic [63:0] fetch_RAS;

    // bench-side environment controls
    logic        addr_ok_en, data_ok_en, ovr_en;
    logic [63:0] ovr_val;
    logic [31:0] tk0_pc, tk0_tgt, tk1_pc, tk1_tgt;
    logic        outstanding;
    logic [31:0] cap_addr;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .bp_pc(bp_pc), .bp_taken0(bp_taken0), .bp_taken1(bp_taken1),
        .bp_target0(bp_target0), .bp_target1(bp_target1), .ras_in(ras_in),
        .flush(flush), .flush_target(flush_target), .buffer_full(buffer_full),
        .fetch_output_en(fetch_output_en),
        .fetch_valid0(fetch_valid0), .fetch_valid1(fetch_valid1),
        .fetch_PC0(fetch_PC0), .fetch_PC1(fetch_PC1),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .fetch_predict0(fetch_predict0), .fetch_predict1(fetch_predict1),
        .fetch_predict_target0(fetch_predict_target0), .fetch_predict_target1(fetch_predict_target1),
        .fetch_excode0(fetch_excode0), .fetch_excode1(fetch_excode1),
        .fetch_RAS(fetch_RAS)
    );

    // memory contents: a fixed scramble of the word address
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign inst_addr_ok = addr_ok_en;
    assign inst_data_ok = outstanding && data_ok_en;
    assign inst_rdata   = ovr_en ? ovr_val : {word(cap_addr + 32'd4), word(cap_addr)};
    assign bp_taken0    = (bp_pc == tk0_pc);
    assign bp_target0   = tk0_tgt;
    assign bp_taken1    = (bp_pc == tk1_pc);
    assign bp_target1   = tk1_tgt;

    // one-deep cache model: remembers the accepted address until data is returned
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= 1'b0;
            cap_addr    <= 32'h0;
        end else if (inst_req && inst_addr_ok) begin
            outstanding <= 1'b1;
            cap_addr    <= inst_addr;
        end else if (inst_data_ok) begin
            outstanding <= 1'b0;
        end
    end

    typedef struct packed {
        logic        v0, v1;
        logic [31:0] pc0, pc1, i0, i1;
        logic        p0, p1;
        logic [31:0] t0, t1;
        logic [3:0]  x0, x1;
        logic [63:0] ras;
    } grp_t;

    grp_t        exp_q[$];
    logic [31:0] req_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          pops     = 0;

    // clear fields that carry no meaning for this group
    function automatic grp_t norm(input grp_t g);
        grp_t r = g;
        if (!r.v1) begin r.pc1 = '0; r.i1 = '0; r.p1 = 1'b0; r.x1 = '0; end
        if (!r.p0) r.t0 = '0;
        if (!r.p1) r.t1 = '0;
        if (r.x0 != 4'd0) r.ras = '0;
        return r;
    endfunction

    function automatic grp_t mk(input logic [31:0] pc, input logic v1, input logic p0,
                                input logic [31:0] t0, input logic p1, input logic [31:0] t1,
                                input logic [63:0] ras);
        grp_t g;
        g.v0 = 1'b1; g.v1 = v1; g.pc0 = pc; g.pc1 = pc + 32'd4;
        g.i0 = word(pc); g.i1 = word(pc + 32'd4);
        g.p0 = p0; g.p1 = p1; g.t0 = t0; g.t1 = t1;
        g.x0 = 4'd0; g.x1 = 4'd0; g.ras = ras;
        return g;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // scoreboard monitor: groups on push, addresses on request acceptance
    always @(negedge clk) begin
        grp_t a, e;
        logic [31:0] ea;
        if (!reset && fetch_output_en && !buffer_full && !flush) begin
            pops++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_push: got PC0 %h expected no push", fetch_PC0);
            end else begin
                e = exp_q.pop_front();
                a.v0 = fetch_valid0; a.v1 = fetch_valid1;
                a.pc0 = fetch_PC0; a.pc1 = fetch_PC1;
                a.i0 = fetch_inst0; a.i1 = fetch_inst1;
                a.p0 = fetch_predict0; a.p1 = fetch_predict1;
                a.t0 = fetch_predict_target0; a.t1 = fetch_predict_target1;
                a.x0 = fetch_excode0; a.x1 = fetch_excode1; a.ras = fetch_RAS;
                if (norm(a) === norm(e)) n_pass++;
                else $display("FAIL group@%h: got %h expected %h", e.pc0, norm(a), norm(e));
            end
        end
        if (!reset && inst_req && inst_addr_ok) begin
            n_checks++;
            if (req_q.size() == 0) begin
                $display("FAIL unexpected_req: got %h expected no request", inst_addr);
            end else begin
                ea = req_q.pop_front();
                if (inst_addr === ea) n_pass++;
                else $display("FAIL req_addr: got %h expected %h", inst_addr, ea);
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        do begin @(posedge clk); k++; end while (pops < n && k < 200);
        #1;
        if (pops < n) begin
            n_checks++;
            $display("FAIL wait_pops: got %0d pushes expected %0d", pops, n);
        end
    endtask

    task automatic wait_en();
        int k = 0;
        while (!fetch_output_en && k < 50) begin cyc(); k++; end
        if (!fetch_output_en) begin
            n_checks++;
            $display("FAIL wait_en: got 0 expected 1");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; flush_target = '0; buffer_full = 1'b0;
        addr_ok_en = 1'b1; data_ok_en = 1'b1; ovr_en = 1'b0; ovr_val = '0;
        tk0_pc = 32'hFFFF_FFFF; tk0_tgt = '0; tk1_pc = 32'hFFFF_FFFF; tk1_tgt = '0;
        ras_in = 64'h1111_2222_3333_4444;

        // reset state
        @(negedge clk); @(negedge clk);
        check("rst_req",   {63'd0, inst_req}, 64'd0);
        check("rst_addr",  {32'd0, inst_addr}, 64'd0);
        check("rst_bp_pc", {32'd0, bp_pc}, 64'd0);
        check("rst_group", {31'd0, fetch_output_en, fetch_valid0, fetch_PC0}, 64'd0);

        // sequential fetch from RESET_PC, then backpressure on the 4th group
        for (int i = 0; i < 4; i++) begin
            req_q.push_back(32'hBFC0_0000 + 32'(8 * i));
            exp_q.push_back(mk(32'hBFC0_0000 + 32'(8 * i), 1'b1, 1'b0, '0, 1'b0, '0, ras_in));
        end
        cyc(); reset = 1'b0;
        @(negedge clk);
        check("first_req_not_yet", {63'd0, inst_req}, 64'd0);
        @(negedge clk);
        check("first_req", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'hBFC0_0000});
        wait_pops(3);
        buffer_full = 1'b1;
        wait_en();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {30'd0, fetch_output_en, inst_req, fetch_PC0}, {30'd0, 1'b1, 1'b0, 32'hBFC0_0018});
        end
        cyc(); buffer_full = 1'b0; addr_ok_en = 1'b0;
        wait_pops(4);
        @(negedge clk);
        check("after_bp_req", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'hBFC0_0020});

        // slot1 predicted taken at 0x1000, then flush while waiting on 0x2000
        cyc();
        ras_in = 64'hAAAA_0000_0000_0001;
        tk1_pc = 32'h1000; tk1_tgt = 32'h2000;
        flush = 1'b1; flush_target = 32'h1000;
        req_q.push_back(32'h1000); req_q.push_back(32'h1008); req_q.push_back(32'h2000);
        exp_q.push_back(mk(32'h1000, 1'b1, 1'b0, '0, 1'b1, 32'h2000, ras_in));
        exp_q.push_back(mk(32'h1008, 1'b0, 1'b0, '0, 1'b0, '0, ras_in));
        cyc(); flush = 1'b0; addr_ok_en = 1'b1;
        wait_pops(6);
        data_ok_en = 1'b0;
        cyc();
        flush = 1'b1; flush_target = 32'h3000; addr_ok_en = 1'b0;
        cyc(); flush = 1'b0; tk1_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("cancel_quiet", {62'd0, inst_req, fetch_output_en}, 64'd0);
            cyc();
        end
        data_ok_en = 1'b1;
        @(posedge clk); @(negedge clk);
        check("redirect_req", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h3000});

        // misaligned redirect: exception group, then stall until next flush
        cyc();
        flush = 1'b1; flush_target = 32'h1002;
        begin
            grp_t g;
            g = mk(32'h1002, 1'b0, 1'b0, '0, 1'b0, '0, '0);
            g.i0 = 32'h0; g.x0 = 4'd4;
            exp_q.push_back(g);
        end
        cyc(); flush = 1'b0;
        @(negedge clk);
        check("adel_no_req", {63'd0, inst_req}, 64'd0);
        wait_pops(7);
        addr_ok_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_quiet", {62'd0, inst_req, fetch_output_en}, 64'd0);
            cyc();
        end
        ras_in = 64'hCCCC_0000_0000_0003;
        flush = 1'b1; flush_target = 32'h4000;
        req_q.push_back(32'h4000);
        exp_q.push_back(mk(32'h4000, 1'b1, 1'b0, '0, 1'b0, '0, ras_in));
        cyc(); flush = 1'b0;
        cyc(); addr_ok_en = 1'b0;
        wait_pops(8);
        @(negedge clk);
        check("resume_next_req", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h4008});

        // odd-word entry at 0x1004
        cyc();
        ras_in = 64'hDDDD_0000_0000_0004;
        ovr_en = 1'b1; ovr_val = 64'hBBBB_BBBB_AAAA_AAAA;
        flush = 1'b1; flush_target = 32'h1004;
        req_q.push_back(32'h1000);
        begin
            grp_t g;
            g = mk(32'h1004, 1'b0, 1'b0, '0, 1'b0, '0, ras_in);
            g.i0 = 32'hBBBB_BBBB;
            exp_q.push_back(g);
        end
        cyc(); flush = 1'b0; addr_ok_en = 1'b1;
        cyc(); addr_ok_en = 1'b0;
        wait_pops(9);
        @(negedge clk);
        check("odd_next_req", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h1008});

        // slot0 predicted taken at 0x1008: pair kept, slot1 is the delay slot
        cyc();
        ovr_en = 1'b0;
        ras_in = 64'hEEEE_0000_0000_0005;
        tk0_pc = 32'h1008; tk0_tgt = 32'h5000;
        req_q.push_back(32'h1008);
        exp_q.push_back(mk(32'h1008, 1'b1, 1'b1, 32'h5000, 1'b0, '0, ras_in));
        addr_ok_en = 1'b1;
        cyc(); addr_ok_en = 1'b0;
        wait_pops(10);
        @(negedge clk);
        check("taken0_next_req", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h5000});

        check("groups_left",   64'(exp_q.size()), 64'd0);
        check("requests_left", 64'(req_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
